regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port data register file, the successor to the single-port `dreg`. It provides NRD combinational read ports and two write ports with a fixed collision priority. An optional lower-to-upper mirror window, optional hardwired-zero entry 0, and optional write-to-read bypass are selected by parameter. A single-cycle shadow bank supports snapshot/restore for context save. It sits between decode (read addresses) and writeback (write ports) in the core datapath.

## Interface
- `WIDTH`, 32, data word width in bits
- `AW`, 5, address width; DEPTH = 2**AW entries (AW ≥ 2)
- `NRD`, 2, number of read ports (≥ 1)
- `MIRROR`, 1, 1 = a write to address a < DEPTH/2 also writes a + DEPTH/2
- `ZERO_R0`, 0, 1 = entry 0 always reads 0 and writes to it are discarded
- `BYPASS`, 1, 1 = reads return the value the entry will hold after the current edge
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ra`  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW]
- `rdata`  out  NRD*WIDTH  packed read data; port i = bits [i*WIDTH +: WIDTH]
- `we0`, `wa0`, `wd0`  in  1/AW/WIDTH  write port 0 enable, address, data
- `we1`, `wa1`, `wd1`  in  1/AW/WIDTH  write port 1 enable, address, data
- `snap`  in  1  copy the live bank into the shadow bank at the edge
- `restore`  in  1  copy the shadow bank into the live bank at the edge

## Operation
- State: live bank L[DEPTH] and shadow bank S[DEPTH], each WIDTH bits. No other state.
- Reset (`rst` high, asynchronous): every L and S entry becomes 0, so every `rdata` reads 0. Reset has priority over all inputs. Deassertion mid-sequence loses all prior contents.
- Effective write set of port p with we_p = 1:
  - Always {wa_p}.
  - Plus {wa_p + DEPTH/2} when MIRROR = 1 and wa_p < DEPTH/2.
  - Writes to an upper-half address never mirror downward.
- ZERO_R0 = 1: a port addressed to 0 is dropped entirely, including its mirror to DEPTH/2. Entry 0 reads 0 regardless of BYPASS.
- Next live value of entry e, applied in this order, later steps overriding earlier ones:
  1. L[e].
  2. S[e] if `restore` is high.
  3. wd0 if e is in port 0's effective write set.
  4. wd1 if e is in port 1's effective write set.
- Consequences of the ordering:
  - Port 1 wins any overlap with port 0, including overlap through mirror aliases.
  - Same-cycle writes override restored values.
- Next shadow value: S[e] ← L[e] (pre-edge contents, excluding same-cycle writes) when `snap` is high, else unchanged.
- `snap` and `restore` together swap the two banks. Same-cycle writes then land on the new live bank.
- Read port i:
  - BYPASS = 0: rdata_i = L[ra_i], the pre-edge value.
  - BYPASS = 1: rdata_i = the computed next live value of entry ra_i, including restore and the write-port priority.
  - ZERO_R0 forces rdata_i = 0 when ra_i = 0.
- Read addresses are unconstrained; all NRD ports may address the same entry.

## Timing
- Reads are purely combinational from `ra`, L, S and the write/restore inputs. Zero cycles of latency.
- Writes, snap and restore take effect at the rising edge of `clk`. They are visible with BYPASS = 0 in the cycle after the edge.
- With BYPASS = 1 the read path spans the write port data, so the timing path is wd → rdata.
- No handshake and no stalls. Every input is sampled every cycle.
- Reset is asynchronous: `rdata` goes to 0 within the same cycle that `rst` rises, with no clock required.

## Test plan
- Reset → all ports read 0. With WIDTH = 32 and AW = 5, write 0xDEADBEEF to 3, assert `rst` mid-cycle → `rdata` for address 3 is 0 before the next edge.
- MIRROR = 1: we0 with wa0 = 5 and wd0 = 0x11 → addresses 5 and 21 both read 0x11. Then wa0 = 21 with wd0 = 0x22 → address 21 reads 0x22 and address 5 still reads 0x11.
- Collision: same cycle, we0 (wa0 = 4, wd0 = 0xA) and we1 (wa1 = 20, wd1 = 0xB) → address 4 reads 0xA and address 20 reads 0xB (port 1 wins the alias). Then wa0 = wa1 = 7 → address 7 reads port 1's data.
- Snapshot/restore: address 2 holds 0x1, pulse `snap`, write 0x9 to 2, pulse `restore` → address 2 reads 0x1. Next, `restore` with a same-cycle write of 0x7 to 2 → address 2 reads 0x7.
- Swap: L[1] = 0xAA and S[1] = 0xBB, assert `snap` and `restore` together → L[1] = 0xBB and S[1] = 0xAA.
- BYPASS = 1 with ZERO_R0 = 1: ra0 = 6 while writing 0x33 to 6 → rdata0 = 0x33 in the same cycle. A write of 0x44 to address 0 → address 0 reads 0, and address 16 is unchanged.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two prioritised write ports,
// optional lower-to-upper mirroring, hardwired zero entry, write bypass and a shadow bank.
module regfile_mp #(
  parameter int WIDTH   = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int MIRROR  = 1,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*AW-1:0]      ra,
  output logic [NRD*WIDTH-1:0]   rdata,
  input  logic                   we0,
  input  logic [AW-1:0]          wa0,
  input  logic [WIDTH-1:0]       wd0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd1,
  input  logic                   snap,
  input  logic                   restore
);
  // No handshake: every input is sampled on every rising edge, reads never stall.
  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] live_q   [DEPTH];
  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [WIDTH-1:0] live_d   [DEPTH];
  logic [DEPTH-1:0] hit0, hit1;

  // One-hot set of entries a write port touches, mirror alias included.
  function automatic logic [DEPTH-1:0] wset(input logic we, input logic [AW-1:0] wa);
    logic [DEPTH-1:0] s;
    s = '0;
    if (we && !(ZERO_R0 != 0 && wa == '0)) begin
      s[wa] = 1'b1;
      if (MIRROR != 0 && !wa[AW-1]) s[{1'b1, wa[AW-2:0]}] = 1'b1;
    end
    return s;
  endfunction

  // Next live value: restore first, then port 0, then port 1 (port 1 wins overlaps).
  always_comb begin
    hit0 = wset(we0, wa0);
    hit1 = wset(we1, wa1);
    for (int e = 0; e < DEPTH; e++) begin
      live_d[e] = live_q[e];
      if (restore) live_d[e] = shadow_q[e];
      if (hit0[e]) live_d[e] = wd0;
      if (hit1[e]) live_d[e] = wd1;
    end
    if (ZERO_R0 != 0) live_d[0] = '0;
  end

  // Snapshot takes pre-edge live contents, so snap+restore swaps the banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        live_q[e]   <= '0;
        shadow_q[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        live_q[e] <= live_d[e];
        if (snap) shadow_q[e] <= live_q[e];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] word;
    assign addr = ra[i*AW +: AW];
    assign word = (BYPASS != 0) ? live_d[addr] : live_q[addr];
    assign rdata[i*WIDTH +: WIDTH] = (rst || (ZERO_R0 != 0 && addr == '0)) ? '0 : word;
  end

endmodule
